// File: rtl/sm3_msg_expnd.sv
// sm3_msg_expnd
// SM3 message expansion stage. Accepts one 512-bit padded message block and
// streams the expanded word pairs W_j / W'_j (j = 0..ROUNDS-1), one pair per
// handshake. A 16-word sliding window produces W_{j+16} on the fly, so the
// full 68-word expansion is never stored.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   blk_valid  in   1    upstream block valid
//   blk_ready  out  1    stage can accept a block (IDLE only)
//   blk_data   in   512  message block; W0 = [511:480], W15 = [31:0]
//   w_valid    out  1    W pair valid (RUN only)
//   w_ready    in   1    downstream accepts the W pair
//   w_j        out  32   W_j
//   w_p_j      out  32   W'_j = W_j ^ W_{j+4}
//   w_idx      out  6    round index j of the current pair
//   w_last     out  1    high with the pair j = ROUNDS-1
module sm3_msg_expnd #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_j,
  output logic [31:0]  w_p_j,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  j_q, j_d;
  logic [31:0] w_new;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // With win[0] = W_j, this is W_{j+16}: win[7]=W_{j+7}, win[13]=W_{j+13},
  // win[3]=W_{j+3}, win[10]=W_{j+10}.
  assign w_new = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15))
               ^ rotl(win_q[3], 7) ^ win_q[10];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int unsigned k = 0; k < 16; k++) begin
            win_d[k] = blk_data[511 - 32*k -: 32];
          end
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          if (j_q == LAST_IDX) begin
            // Window and index hold; the next block reloads both.
            state_d = IDLE;
          end else begin
            for (int unsigned k = 0; k < 15; k++) begin
              win_d[k] = win_q[k + 1];
            end
            win_d[15] = w_new;
            j_d       = j_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      j_q     <= j_d;
    end
  end

  assign blk_ready = (state_q == IDLE);
  assign w_valid   = (state_q == RUN);
  assign w_j       = win_q[0];
  assign w_p_j     = win_q[0] ^ win_q[4];
  assign w_idx     = j_q;
  assign w_last    = (state_q == RUN) && (j_q == LAST_IDX);

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// Self-checking bench for sm3_msg_expnd: scoreboard of expected pairs built
// from a full 68-word SM3 expansion, checked on every clock.
module tb_sm3_msg_expnd;

  localparam int unsigned ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_j;
  logic [31:0]  w_p_j;
  logic [5:0]   w_idx;
  logic         w_last;

  sm3_msg_expnd #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_j(w_j), .w_p_j(w_p_j), .w_idx(w_idx), .w_last(w_last)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef logic [31:0] warr_t [68];
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] wp;
    logic [5:0]  idx;
    logic        last;
  } pair_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic warr_t expand(input logic [511:0] b);
    warr_t w;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++)
      w[i] = p1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
    return w;
  endfunction

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  pair_t       q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_cyc = 0;
  int          first_cyc = 0;
  bit          want_first = 0;
  int          got_cnt = 0;
  int          last_cnt = 0;
  logic [31:0] got_w  [64];
  logic [31:0] got_wp [64];
  int          rdy_mode = 0;

  // w_ready driver: 0 = always ready, 1 = 50 %, 2 = 75 %
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       w_ready = ($urandom_range(0, 1) != 0);
        2:       w_ready = ($urandom_range(0, 3) != 0);
        default: w_ready = 1'b1;
      endcase
    end
  end

  // Compare process: sample mid-cycle, handshakes complete at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("w_valid", w_valid, q.size() != 0);
      chk("blk_ready", blk_ready, q.size() == 0);
      if (w_valid && q.size() != 0) begin
        if (want_first) begin
          first_cyc  = cyc;
          want_first = 0;
        end
        chk("w_j", w_j, q[0].w);
        chk("w_p_j", w_p_j, q[0].wp);
        chk("w_idx", w_idx, q[0].idx);
        chk("w_last", w_last, q[0].last);
        if (w_ready) begin
          if (got_cnt < 64) begin
            got_w[w_idx]  = w_j;
            got_wp[w_idx] = w_p_j;
          end
          got_cnt++;
          if (w_last) begin
            last_cnt++;
            last_cyc = cyc;
          end
          void'(q.pop_front());
        end
      end
      if (blk_valid && blk_ready) begin
        warr_t e;
        e = expand(blk_data);
        for (int j = 0; j < ROUNDS; j++)
          q.push_back('{w: e[j], wp: e[j] ^ e[j+4], idx: 6'(j), last: (j == ROUNDS - 1)});
        acc_cyc    = cyc;
        want_first = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(blk_ready && rst_n) && n < 2000);
    if (n >= 2000) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic send_block(input logic [511:0] b);
    @(posedge clk);
    #2;
    blk_valid = 1'b1;
    blk_data  = b;
    wait_accept();
    blk_valid = 1'b0;
    blk_data  = rand_blk();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || w_valid) && n < 5000);
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic clear_got();
    got_cnt  = 0;
    last_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      got_w[i]  = '0;
      got_wp[i] = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [511:0] abc_blk, ff_blk, b1, b2;
  logic [31:0]  ref_w  [64];
  warr_t        m;
  int           diffs;

  initial begin
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    ff_blk    = '1;
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    #1;
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_idx", w_idx, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_w_j", w_j, 0);
    chk("rst_w_p_j", w_p_j, 0);

    // Hand-computed values pinning the model.
    m = expand(abc_blk);
    chk("model_abc_w16", m[16], 32'h9092E200);
    chk("model_abc_w18", m[18], 32'h000C0606);
    chk("model_abc_wp0", m[0] ^ m[4], 32'h61626380);
    m = expand(ff_blk);
    chk("model_ff_wp11", m[11] ^ m[15], 32'h0);

    #21 rst_n = 1'b1;

    // 1: abc, always ready
    rdy_mode = 0;
    clear_got();
    send_block(abc_blk);
    wait_idle();
    chk("t1_first_latency", first_cyc - acc_cyc, 1);
    chk("t1_pairs", got_cnt, 64);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_w0", got_w[0], 32'h61626380);
    chk("t1_wp0", got_wp[0], 32'h61626380);
    chk("t1_w16", got_w[16], 32'h9092E200);
    chk("t1_w18", got_w[18], 32'h000C0606);
    for (int i = 0; i < 64; i++) ref_w[i] = got_w[i];

    // 2: abc, random backpressure
    rdy_mode = 1;
    clear_got();
    send_block(abc_blk);
    wait_idle();
    diffs = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) diffs++;
    chk("t2_seq_diffs", diffs, 0);
    chk("t2_pairs", got_cnt, 64);

    // 3: blk_valid held high across two blocks
    rdy_mode = 0;
    b1 = rand_blk();
    b2 = rand_blk();
    @(posedge clk);
    #2;
    blk_valid = 1'b1;
    blk_data  = b1;
    wait_accept();
    blk_data = b2;
    wait_accept();
    chk("t3_bubble", acc_cyc - last_cyc, 1);
    blk_valid = 1'b0;
    wait_idle();

    // 4: 100 random blocks with backpressure
    rdy_mode = 2;
    for (int k = 0; k < 100; k++) send_block(rand_blk());
    wait_idle();

    // 5: reset mid-block at w_idx == 20
    rdy_mode = 0;
    send_block(rand_blk());
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(w_valid && w_idx == 6'd20) && n < 200);
      if (n >= 200) chk("t5_idx20_timeout", 1, 0);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5_w_valid", w_valid, 0);
    chk("t5_blk_ready", blk_ready, 1);
    chk("t5_w_idx", w_idx, 0);
    q.delete();
    want_first = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_got();
    send_block(abc_blk);
    wait_idle();
    chk("t5_w0", got_w[0], 32'h61626380);
    chk("t5_pairs", got_cnt, 64);

    // 6: all-FF block
    rdy_mode = 1;
    clear_got();
    send_block(ff_blk);
    wait_idle();
    for (int j = 0; j < 12; j++) chk($sformatf("t6_wp%0d", j), got_wp[j], 32'h0);
    m = expand(ff_blk);
    chk("t6_w16", got_w[16], m[16]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
